oled_frame_refresh: RTL
=======================

# oled_frame_refresh

Streams a full frame from the display RAM to the OLED panel over the shared I2C byte driver once panel initialisation has completed. Sits downstream of the initialisation sequencer: it waits for `init_done`, then, for every refresh request, sends per-page addressing commands (dc=0) followed by that page's column data bytes (dc=1), one byte per driver transaction. Owns the driver's `dc`/`din`/`iic_start` inputs after initialisation; the top level muxes these on `init_done`.

## Interface
- `COLS`, 128: columns per page (data bytes per page).
- `PAGES`, 8: pages per frame.
- `ADDR_W`, 10: framebuffer address width; must satisfy 2^ADDR_W ≥ COLS*PAGES.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `init_done` in 1: level; high once panel initialisation has finished.
- `refresh_req` in 1: single-cycle request to send one frame.
- `busy` out 1: high from frame start until `frame_done`.
- `frame_done` out 1: one-cycle pulse after the last data byte's `iic_done`.
- `fb_addr` out ADDR_W: framebuffer read address = page*COLS + col.
- `fb_data` in 8: framebuffer read data; synchronous RAM, valid one cycle after `fb_addr`.
- `iic_dc` out 1: 0 = command byte, 1 = data byte.
- `iic_din` out 8: byte to send.
- `iic_start` out 1: one-cycle registered pulse starting a driver transaction.
- `iic_done` in 1: one-cycle pulse from the driver when a byte transaction ends.

## Operation
- States: IDLE, CMD, CMD_WAIT, RD_ADDR, RD_DATA, DAT, DAT_WAIT, FIN.
- IDLE: if `init_done` and (`refresh_req` or `pending`) → clear `pending`, page=0, cmd_idx=0, `busy`=1, go to CMD.
- CMD: load `iic_din` with the cmd_idx command: 0 → 0xB0|page[2:0], 1 → 0x00 (low column nibble), 2 → 0x10 (high column nibble); `iic_dc`=0; pulse `iic_start`; go to CMD_WAIT.
- CMD_WAIT: on `iic_done`: if cmd_idx==2 → col=0, go to RD_ADDR; otherwise cmd_idx+1, go to CMD.
- RD_ADDR: drive `fb_addr`=page*COLS+col; go to RD_DATA.
- RD_DATA: wait one cycle for RAM latency; go to DAT.
- DAT: `iic_din`=`fb_data`, `iic_dc`=1, pulse `iic_start`; go to DAT_WAIT.
- DAT_WAIT: on `iic_done`: if col==COLS-1 and page==PAGES-1 → FIN; if col==COLS-1 → page+1, cmd_idx=0, go to CMD; otherwise col+1, go to RD_ADDR.
- FIN: pulse `frame_done`, `busy`=0, go to IDLE.
- `refresh_req` while `busy` (or while `init_done`=0) sets `pending`; multiple requests collapse into one. A request arriving in the same cycle as FIN is held pending and starts the next frame immediately from IDLE.
- `init_done` is sampled only in IDLE; a frame in progress is always completed.
- Counters: col is log2(COLS) bits, page is log2(PAGES) bits; no wrap beyond the terminal values, because terminal compares precede increments.

## Timing
- Reset values: `busy`=0, `frame_done`=0, `iic_start`=0, `iic_dc`=0, `iic_din`=0x00, `fb_addr`=0, `pending`=0, state=IDLE.
- `iic_start` is high for exactly one cycle per byte. `iic_din`/`iic_dc` are registered in the same edge and stay stable until the next start.
- An `iic_done` that arrives outside CMD_WAIT/DAT_WAIT is ignored.
- From request to first `iic_start`: 2 cycles (IDLE→CMD registered, pulse out).
- Overhead per data byte beyond driver time: 3 cycles (RD_ADDR, RD_DATA, DAT).
- Per frame: PAGES*(3+COLS) = 1048 `iic_start` pulses at the defaults.
- `rst` mid-frame: next cycle state=IDLE, all outputs at reset values, pending request discarded.

## Test plan
- Reset, then hold `init_done`=0 and pulse `refresh_req` → no `iic_start`. Raise `init_done` → frame starts within 2 cycles (pending honoured).
- Driver model with done 20 cycles after start, RAM[i]=i[7:0] → captured sequence per page p is B0+p, 00, 10, then bytes (p*128+c)&0xFF with dc 0,0,0,1…; exactly 1048 starts; one `frame_done` pulse.
- Three `refresh_req` pulses during a frame → exactly one extra frame follows, and `busy` stays high across the gap except in the FIN→IDLE cycle.
- `refresh_req` coincident with FIN → second frame starts; `frame_done` is still a single-cycle pulse.
- Assert `rst` in page 3, column 50 → next cycle all outputs are 0, no further starts; a new request restarts at command 0xB0.
- Spurious `iic_done` while in RD_ADDR/RD_DATA → byte sequence is unchanged, with no skipped or duplicated bytes.

Source files
------------

// File: rtl/oled_frame_refresh.sv
`timescale 1ns/1ps
// Frame streamer: after panel init, sends page address commands then
// column data bytes from the framebuffer, one I2C byte per transaction.
// Ports: clk/rst (sync, active-high); init_done, refresh_req in;
//   busy, frame_done status out; fb_addr out / fb_data in (1-cycle RAM);
//   iic_dc, iic_din, iic_start to byte driver; iic_done from driver.
module oled_frame_refresh #(
  parameter int COLS   = 128,
  parameter int PAGES  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              refresh_req,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic              iic_dc,
  output logic [7:0]        iic_din,
  output logic              iic_start,
  input  logic              iic_done
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, CMD_WAIT, RD_ADDR,
    RD_DATA, DAT, DAT_WAIT, FIN
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [PW-1:0]     page_q, page_d;
  logic [1:0]        cmd_idx_q, cmd_idx_d;
  logic              pending_q, pending_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              iic_start_q, iic_start_d;
  logic              iic_dc_q, iic_dc_d;
  logic [7:0]        iic_din_q, iic_din_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [2:0]        page3;

  assign page3 = 3'(page_q);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    page_d       = page_q;
    cmd_idx_d    = cmd_idx_q;
    pending_d    = pending_q | refresh_req;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    iic_start_d  = 1'b0;
    iic_dc_d     = iic_dc_q;
    iic_din_d    = iic_din_q;
    fb_addr_d    = fb_addr_q;
    unique case (state_q)
      IDLE: begin
        if (init_done && (refresh_req || pending_q)) begin
          pending_d = 1'b0;
          page_d    = '0;
          cmd_idx_d = '0;
          busy_d    = 1'b1;
          state_d   = CMD;
        end
      end
      CMD: begin
        iic_dc_d    = 1'b0;
        iic_start_d = 1'b1;
        unique case (cmd_idx_q)
          2'd0:    iic_din_d = {5'b10110, page3};
          2'd1:    iic_din_d = 8'h00;
          default: iic_din_d = 8'h10;
        endcase
        state_d = CMD_WAIT;
      end
      CMD_WAIT: begin
        if (iic_done) begin
          if (cmd_idx_q == 2'd2) begin
            col_d   = '0;
            state_d = RD_ADDR;
          end else begin
            cmd_idx_d = cmd_idx_q + 2'd1;
            state_d   = CMD;
          end
        end
      end
      RD_ADDR: begin
        fb_addr_d = ADDR_W'(page_q) * COLS_A
                  + ADDR_W'(col_q);
        state_d   = RD_DATA;
      end
      RD_DATA: state_d = DAT;
      DAT: begin
        iic_din_d   = fb_data;
        iic_dc_d    = 1'b1;
        iic_start_d = 1'b1;
        state_d     = DAT_WAIT;
      end
      DAT_WAIT: begin
        if (iic_done) begin
          if (col_q == COL_LAST && page_q == PAGE_LAST) begin
            state_d = FIN;
          end else if (col_q == COL_LAST) begin
            page_d    = page_q + 1'b1;
            cmd_idx_d = '0;
            state_d   = CMD;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = RD_ADDR;
          end
        end
      end
      FIN: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      page_q       <= '0;
      cmd_idx_q    <= '0;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      iic_start_q  <= 1'b0;
      iic_dc_q     <= 1'b0;
      iic_din_q    <= 8'h00;
      fb_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      page_q       <= page_d;
      cmd_idx_q    <= cmd_idx_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      iic_start_q  <= iic_start_d;
      iic_dc_q     <= iic_dc_d;
      iic_din_q    <= iic_din_d;
      fb_addr_q    <= fb_addr_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign iic_start  = iic_start_q;
  assign iic_dc     = iic_dc_q;
  assign iic_din    = iic_din_q;
  assign fb_addr    = fb_addr_q;

endmodule
